// File: rtl/dbg_pkg.sv
// Shared types for the instruction-memory debug readback engine.
package dbg_pkg;

  localparam int unsigned DBG_XLEN   = 32;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } rd_state_e;

  typedef struct packed {
    logic [DBG_XLEN-1:0] data;
    logic [DBG_XLEN-1:0] addr;
    logic                last;
  } out_word_t;

endpackage

// File: rtl/dbg_rd_fifo.sv
// Two-entry valid/ready FIFO for readback words; occupancy feeds the read credit check.
module dbg_rd_fifo
  import dbg_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  out_word_t push_word,
  input  logic      pop_ready,
  output logic      head_valid,
  output out_word_t head_word,
  output logic [1:0] occupancy
);

  out_word_t  mem_q [2];
  logic       wptr_q, rptr_q;
  logic [1:0] cnt_q, cnt_d;
  logic       pop;

  always_comb begin
    pop   = pop_ready & (cnt_q != 2'd0);
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= push_word;
        wptr_q        <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign head_valid = (cnt_q != 2'd0);
  assign head_word  = mem_q[rptr_q];
  assign occupancy  = cnt_q;

endmodule

// File: rtl/dbg_mem_reader.sv
// Burst readback of instruction memory through a 1-cycle synchronous read port,
// streamed out with byte addresses over valid/ready.
module dbg_mem_reader
  import dbg_pkg::*;
#(
  parameter int unsigned XLEN  = DBG_XLEN,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_start,
  input  logic [XLEN-1:0]  rd_base_addr,
  input  logic [LEN_W-1:0] rd_len,
  output logic             rd_busy,
  output logic             rd_done,
  output logic             rd_err,
  output logic             mem_rd_en,
  output logic [XLEN-1:0]  mem_rd_addr,
  input  logic [XLEN-1:0]  mem_rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [XLEN-1:0]  out_addr,
  output logic             out_last
);

  rd_state_e        state_q, state_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             infl_q;
  logic [XLEN-1:0]  infl_addr_q;
  logic             infl_last_q;

  logic       issue, pop;
  logic [1:0] occupancy;
  logic [2:0] occ_after;
  out_word_t  push_word, head_word;

  // Words still owed after this edge; a pop this cycle frees a slot for a same-cycle issue.
  assign pop       = out_valid & out_ready;
  assign occ_after = {1'b0, occupancy} + {2'b00, infl_q} - {2'b00, pop};
  assign issue     = (state_q == StIssue) && (occ_after < 3'd2);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (rd_start) begin
          if (rd_base_addr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (rd_len == '0) begin
            err_d   = 1'b0;
            state_d = StDone;
          end else begin
            err_d   = 1'b0;
            addr_d  = rd_base_addr;
            cnt_d   = rd_len;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (issue) begin
          addr_d = addr_q + XLEN'(WORD_BYTES);
          cnt_d  = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && head_word.last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      infl_q      <= issue;
      infl_addr_q <= addr_q;
      infl_last_q <= (cnt_q == LEN_W'(1));
    end
  end

  assign push_word = '{data: mem_rd_data, addr: infl_addr_q, last: infl_last_q};

  dbg_rd_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (infl_q),
    .push_word  (push_word),
    .pop_ready  (out_ready),
    .head_valid (out_valid),
    .head_word  (head_word),
    .occupancy  (occupancy)
  );

  assign mem_rd_en   = issue;
  assign mem_rd_addr = addr_q;
  assign out_data    = head_word.data;
  assign out_addr    = head_word.addr;
  assign out_last    = head_word.last;
  assign rd_busy     = (state_q == StIssue) || (state_q == StDrain);
  assign rd_done     = (state_q == StDone);
  assign rd_err      = (state_q == StDone) && err_q;

endmodule

// File: tb/tb_dbg_mem_reader.sv
// Directed bench for dbg_mem_reader with a behavioural 1-cycle-latency instruction memory.
module tb_dbg_mem_reader;

  localparam int XLEN  = 32;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             rd_start = 1'b0;
  logic [XLEN-1:0]  rd_base_addr = '0;
  logic [LEN_W-1:0] rd_len = '0;
  logic             rd_busy, rd_done, rd_err;
  logic             mem_rd_en;
  logic [XLEN-1:0]  mem_rd_addr;
  logic [XLEN-1:0]  mem_rd_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [XLEN-1:0]  out_data, out_addr;
  logic             out_last;

  logic             dbg_wr_en = 1'b0;
  logic [XLEN-1:0]  dbg_addr = '0;
  logic [XLEN-1:0]  dbg_instr = '0;
  logic [XLEN-1:0]  mem [64];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dbg_mem_reader #(.XLEN(XLEN), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_start     (rd_start),
    .rd_base_addr (rd_base_addr),
    .rd_len       (rd_len),
    .rd_busy      (rd_busy),
    .rd_done      (rd_done),
    .rd_err       (rd_err),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_addr     (out_addr),
    .out_last     (out_last)
  );

  always @(posedge clk) begin
    if (dbg_wr_en) mem[dbg_addr[7:2]] <= dbg_instr;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[7:2]];
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: transfers, read strobes, done pulses, outstanding words, stall stability.
  int          en_cnt = 0;
  int          done_cnt = 0;
  int          issued_tot = 0;
  int          xfer_tot = 0;
  int          maxout = 0;
  logic        prev_stall = 1'b0;
  logic [64:0] prev_word = '0;
  logic [31:0] obs_data [$];
  logic [31:0] obs_addr [$];
  logic        obs_last [$];

  always @(negedge clk) begin
    if (!rst) begin
      issued_tot = 0;
      xfer_tot   = 0;
      prev_stall = 1'b0;
    end else begin
      if (issued_tot - xfer_tot > maxout) maxout = issued_tot - xfer_tot;
      if (prev_stall) chk("stall_hold", {out_valid, out_data, out_addr, out_last}, {1'b1, prev_word});
      if (mem_rd_en) begin
        chk("en_only_busy", rd_busy, 1'b1);
        en_cnt++;
        issued_tot++;
      end
      if (out_valid && out_ready) begin
        obs_data.push_back(out_data);
        obs_addr.push_back(out_addr);
        obs_last.push_back(out_last);
        xfer_tot++;
      end
      if (rd_done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_data, out_addr, out_last};
    end
  end

  // Backpressure pattern 1010 0011 applied while enabled.
  logic       toggle_en = 1'b0;
  logic [7:0] pat = 8'b1100_0101;
  int         pidx = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) begin
        out_ready = pat[pidx];
        pidx      = (pidx + 1) % 8;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_write(input logic [31:0] a, input logic [31:0] d);
    dbg_wr_en = 1'b1;
    dbg_addr  = a;
    dbg_instr = d;
    step();
    dbg_wr_en = 1'b0;
  endtask

  task automatic start(input logic [31:0] base, input logic [7:0] len);
    rd_base_addr = base;
    rd_len       = len;
    rd_start     = 1'b1;
    step();
    rd_start     = 1'b0;
  endtask

  task automatic wait_done(output int n, output logic err);
    n   = -1;
    err = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (rd_done) begin
        n   = i;
        err = rd_err;
        break;
      end
    end
  endtask

  task automatic chk_word(input string tag, input int idx, input logic [31:0] d,
                          input logic [31:0] a, input logic l);
    chk($sformatf("%s_w%0d", tag, idx),
        {obs_data[idx], obs_addr[idx], obs_last[idx]}, {d, a, l});
  endtask

  int   n, ob, eb, db;
  logic err;

  initial begin
    #1;
    chk("rst_outputs", {rd_busy, rd_done, rd_err, mem_rd_en, mem_rd_addr, out_valid,
                        out_data, out_addr, out_last}, '0);
    step();
    step();
    rst = 1'b1;
    step();
    for (int i = 0; i < 64; i++) dbg_write(32'(i * 4), 32'hA500_0000 | 32'(i));

    // Two-word burst, ready held high.
    dbg_write(32'd4, 32'h00C0_0093);
    dbg_write(32'd8, 32'h0020_0113);
    ob = obs_data.size(); eb = en_cnt;
    start(32'd4, 8'd2);
    chk("t1_busy", rd_busy, 1'b1);
    @(negedge clk); chk("t1_c1", {mem_rd_en, mem_rd_addr, out_valid}, {1'b1, 32'd4, 1'b0});
    @(negedge clk); chk("t1_c2", {mem_rd_en, mem_rd_addr, out_valid}, {1'b1, 32'd8, 1'b0});
    @(negedge clk); chk("t1_c3", {out_valid, out_data}, {1'b1, 32'h00C0_0093});
    wait_done(n, err);
    chk("t1_done_lat", n, 2);
    chk("t1_err", err, 1'b0);
    chk("t1_busy_at_done", rd_busy, 1'b0);
    chk("t1_en_cnt", en_cnt - eb, 2);
    chk("t1_nwords", obs_data.size() - ob, 2);
    chk_word("t1", ob, 32'h00C0_0093, 32'd4, 1'b0);
    chk_word("t1", ob + 1, 32'h0020_0113, 32'd8, 1'b1);
    step();

    // Three-word burst under toggling backpressure.
    dbg_write(32'd24, 32'h4020_D1B3);
    ob = obs_data.size(); eb = en_cnt;
    toggle_en = 1'b1;
    start(32'd16, 8'd3);
    wait_done(n, err);
    toggle_en = 1'b0;
    out_ready = 1'b1;
    chk("t2_done_seen", n > 0, 1'b1);
    chk("t2_err", err, 1'b0);
    chk("t2_en_cnt", en_cnt - eb, 3);
    chk("t2_nwords", obs_data.size() - ob, 3);
    chk_word("t2", ob, 32'hA500_0004, 32'd16, 1'b0);
    chk_word("t2", ob + 1, 32'hA500_0005, 32'd20, 1'b0);
    chk_word("t2", ob + 2, 32'h4020_D1B3, 32'd24, 1'b1);
    step();

    // Zero length.
    ob = obs_data.size(); eb = en_cnt;
    start(32'h40, 8'd0);
    wait_done(n, err);
    chk("t3_done_lat", n, 1);
    chk("t3_err", err, 1'b0);
    chk("t3_en_cnt", en_cnt - eb, 0);
    chk("t3_nwords", obs_data.size() - ob, 0);
    step();

    // Misaligned base.
    ob = obs_data.size(); eb = en_cnt;
    start(32'd6, 8'd4);
    wait_done(n, err);
    chk("t4_done_lat", n, 1);
    chk("t4_err", err, 1'b1);
    chk("t4_en_cnt", en_cnt - eb, 0);
    chk("t4_nwords", obs_data.size() - ob, 0);
    step();
    chk("t4_err_pulse", {rd_err, rd_done}, 2'b00);

    // Address wrap at the top of the byte space.
    dbg_write(32'hFFFF_FFFC, 32'hCAFE_0001);
    dbg_write(32'h0000_0000, 32'h0000_0013);
    ob = obs_data.size(); eb = en_cnt;
    start(32'hFFFF_FFFC, 8'd2);
    wait_done(n, err);
    chk("t5_done_lat", n, 5);
    chk("t5_en_cnt", en_cnt - eb, 2);
    chk_word("t5", ob, 32'hCAFE_0001, 32'hFFFF_FFFC, 1'b0);
    chk_word("t5", ob + 1, 32'h0000_0013, 32'h0000_0000, 1'b1);
    step();

    // Start while busy is ignored.
    ob = obs_data.size(); eb = en_cnt;
    start(32'h20, 8'd4);
    step();
    chk("t6_busy", rd_busy, 1'b1);
    start(32'h80, 8'd2);
    wait_done(n, err);
    chk("t6_done_lat", n, 5);
    chk("t6_en_cnt", en_cnt - eb, 4);
    chk("t6_nwords", obs_data.size() - ob, 4);
    for (int i = 0; i < 4; i++)
      chk_word("t6", ob + i, 32'hA500_0008 + 32'(i), 32'h20 + 32'(4 * i), i == 3);
    step();

    // Reset mid-burst, then a fresh burst.
    out_ready = 1'b0;
    start(32'h0, 8'd8);
    step(); step(); step();
    chk("t7_stalled_valid", out_valid, 1'b1);
    db = done_cnt;
    rst = 1'b0;
    #1;
    chk("t7_rst_outputs", {rd_busy, rd_done, rd_err, mem_rd_en, mem_rd_addr, out_valid,
                           out_data, out_addr, out_last}, '0);
    step(); step();
    rst = 1'b1;
    step();
    chk("t7_no_done", done_cnt - db, 0);
    chk("t7_idle_after_rst", {rd_busy, out_valid}, 2'b00);
    out_ready = 1'b1;
    ob = obs_data.size(); eb = en_cnt;
    start(32'd4, 8'd2);
    wait_done(n, err);
    chk("t7_done_lat", n, 5);
    chk("t7_en_cnt", en_cnt - eb, 2);
    chk_word("t7", ob, 32'h00C0_0093, 32'd4, 1'b0);
    chk_word("t7", ob + 1, 32'h0020_0113, 32'd8, 1'b1);
    step();

    chk("max_outstanding_le2", maxout <= 2, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/dbg_mem_reader.md
Name: dbg_mem_reader

Overview:
Debug readback engine for the cpuCore instruction memory. It is the read-side counterpart to the dbg_wr_en/dbg_addr/dbg_instr load path. On a start pulse it issues a burst of word reads to a synchronous 1-cycle-latency memory read port. Each word is streamed out on a valid/ready interface with its byte address, so a host or bench can verify loaded programs while the core is held in reset.

Parameters:
XLEN, 32, data and byte-address width
LEN_W, 8, width of the burst length field (max burst 2^LEN_W-1 words)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
rd_start  in  1  single-cycle request; sampled only when rd_busy=0
rd_base_addr  in  XLEN  byte address of first word; must be word-aligned
rd_len  in  LEN_W  number of words to read
rd_busy  out  1  high from the cycle after an accepted start until the done pulse
rd_done  out  1  one-cycle pulse when the burst completes (normal, zero-length or error)
rd_err  out  1  one-cycle pulse, coincident with rd_done, for a misaligned base
mem_rd_en  out  1  memory read strobe
mem_rd_addr  out  XLEN  memory byte address
mem_rd_data  in  XLEN  read data, valid the cycle after mem_rd_en
out_valid  out  1  output word valid
out_ready  in  1  consumer ready
out_data  out  XLEN  instruction word
out_addr  out  XLEN  byte address of out_data
out_last  out  1  marks the final word of the burst

Behaviour:
- Reset (rst=0, async): every output is 0; FSM=IDLE; FIFO empty; in-flight memory data is discarded. Reset mid-burst aborts the burst with no done pulse.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE + rd_start:
  - rd_base_addr[1:0]!=0 -> DONE with rd_err.
  - rd_len==0 -> DONE, no read.
  - Otherwise latch base and len, set issue counter=len -> ISSUE.
- rd_start while rd_busy=1 is ignored.
- ISSUE: assert mem_rd_en when credits allow. Condition: (FIFO occupancy + reads in flight) < 2.
  - On each issue, mem_rd_addr = current address; address += 4, modulo 2^XLEN (0xFFFFFFFC wraps to 0); counter decrements.
  - Counter reaches 0 -> DRAIN.
- Read timing:
  - First mem_rd_en is asserted in the cycle after the start edge.
  - mem_rd_data is pushed into the FIFO on the next edge, tagged with its address and a last flag (last = final issued word).
  - out_valid rises 2 cycles after the start edge.
- Output: head of a 2-entry FIFO. A transfer occurs when out_valid & out_ready. With out_ready held high, throughput is 1 word/cycle.
- Backpressure: out_data/out_addr/out_last remain stable while out_valid=1 and out_ready=0. No word is lost or duplicated, and there are never more than 2 words outstanding.
- DRAIN -> DONE on the out_last transfer.
- DONE: rd_done pulses for 1 cycle, rd_busy=0 in that cycle, then IDLE.
  - A new rd_start is accepted in the DONE cycle's following cycle.
  - Error and zero-length cases reach DONE 1 cycle after the start edge.
- mem_rd_en is never asserted outside ISSUE.

Decomposition:
- Package dbg_pkg: FSM state enum, WORD_BYTES=4 constant, and a packed out-word struct {data, addr, last}.
- One sub-module, dbg_rd_fifo: a 2-entry valid/ready FIFO holding the struct and exposing its occupancy for the credit check.

Test Plan:
- Load 0x00C00093 @4 and 0x00200113 @8 via the debug write path; start base=4, len=2, out_ready=1 -> out (0x00C00093, 4, last=0) then (0x00200113, 8, last=1); rd_done 1 cycle after last; exactly 2 mem_rd_en pulses.
- Load 0x4020D1B3 @24; base=16, len=3, out_ready toggling 1010/0011 -> addrs 16, 20, 24 in order; 0x4020D1B3 at 24; data stable while stalled; outstanding reads never exceed 2.
- len=0 -> rd_done next cycle, rd_err=0, no mem_rd_en, no out_valid.
- base=6, len=4 -> rd_err and rd_done pulse together; no mem_rd_en.
- base=0xFFFFFFFC, len=2 -> out_addr 0xFFFFFFFC then 0x00000000.
- Second rd_start while busy is ignored (burst count unchanged). Then rst=0 mid-burst -> all outputs 0 immediately, no rd_done; a fresh start after release works normally.
